// File: rtl/mtr_pkg.sv
// Shared motor-drive types and constants. The PID stage uses the same speed and
// duty types, so both ends agree on the 11-bit signed command encoding.
package mtr_pkg;

    localparam logic [10:0] DUTY_OFFSET = 11'h400;
    localparam int          PWM_PERIOD  = 2048;

    typedef logic signed [10:0] spd_t;
    typedef logic        [10:0] duty_t;

    // Offset-binary conversion: adding 0x400 to a signed 11-bit value only flips the sign bit
    function automatic duty_t spd_to_duty(input spd_t spd);
        return {~spd[10], spd[9:0]};
    endfunction

endpackage

// File: rtl/pwm_nonoverlap.sv
// One side of the H-bridge drive: double-buffered duty, raw compare against the
// shared period counter, and dead-time insertion producing complementary outputs.
module pwm_nonoverlap
    import mtr_pkg::*;
#(
    parameter int NONOVERLAP = 32,
    parameter int CNT_W      = 11
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] i_cnt,
    input  spd_t             i_spd,
    input  logic             i_load,
    output logic             o_pwm1,
    output logic             o_pwm2
);

    localparam int               RUN_W   = $clog2(NONOVERLAP + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(NONOVERLAP);

    duty_t            r_duty_q;
    logic             r_raw_q;
    logic [RUN_W-1:0] r_run;
    logic             r_pwm1;
    logic             r_pwm2;
    logic             w_raw;
    logic [RUN_W-1:0] w_run_nxt;

    // Duty is only taken at the period boundary so a mid-period command change never
    // produces a truncated or stretched pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_q <= DUTY_OFFSET;
        end else if (i_load) begin
            r_duty_q <= spd_to_duty(i_spd);
        end
    end

    assign w_raw = (i_cnt < r_duty_q);

    // Length of the raw run including the current cycle, saturating at the dead-time window
    always_comb begin
        w_run_nxt = RUN_W'(1);
        if (w_raw == r_raw_q) begin
            w_run_nxt = (r_run == RUN_MAX) ? RUN_MAX : r_run + 1'b1;
        end
    end

    // A side's output turns on only once raw has held its level for a full window,
    // which guarantees both outputs are low across every raw transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw_q <= 1'b0;
            r_run   <= '0;
            r_pwm1  <= 1'b0;
            r_pwm2  <= 1'b0;
        end else begin
            r_raw_q <= w_raw;
            r_run   <= w_run_nxt;
            r_pwm1  <= w_raw && (w_run_nxt == RUN_MAX);
            r_pwm2  <= !w_raw && (w_run_nxt == RUN_MAX);
        end
    end

    assign o_pwm1 = r_pwm1;
    assign o_pwm2 = r_pwm2;

endmodule

// File: rtl/mtr_drv_pwm.sv
// Dual-side motor PWM driver: one shared free-running period counter feeding two
// independent non-overlapped complementary PWM generators.
module mtr_drv_pwm
    import mtr_pkg::*;
#(
    parameter int NONOVERLAP = 32,
    parameter int CNT_W      = 11
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic signed [10:0] lft_spd,
    input  logic signed [10:0] rght_spd,
    output logic              lftPWM1,
    output logic              lftPWM2,
    output logic              rghtPWM1,
    output logic              rghtPWM2,
    output logic              pwm_sync
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << CNT_W) - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'((1 << CNT_W) - 2);

    logic [CNT_W-1:0] r_cnt;
    logic             r_sync;
    logic             w_load;

    // Free-running period counter; wraps naturally at full scale
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Decoding one count early lets the flopped sync pulse line up with the last count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 1'b0;
        end else begin
            r_sync <= (r_cnt == CNT_PRE);
        end
    end

    assign w_load   = (r_cnt == CNT_LAST);
    assign pwm_sync = r_sync;

    pwm_nonoverlap #(
        .NONOVERLAP (NONOVERLAP),
        .CNT_W      (CNT_W)
    ) u_lft (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_cnt  (r_cnt),
        .i_spd  (lft_spd),
        .i_load (w_load),
        .o_pwm1 (lftPWM1),
        .o_pwm2 (lftPWM2)
    );

    pwm_nonoverlap #(
        .NONOVERLAP (NONOVERLAP),
        .CNT_W      (CNT_W)
    ) u_rght (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_cnt  (r_cnt),
        .i_spd  (rght_spd),
        .i_load (w_load),
        .o_pwm1 (rghtPWM1),
        .o_pwm2 (rghtPWM2)
    );

endmodule

// File: tb/tb_mtr_drv_pwm.sv
// Bench for mtr_drv_pwm: a history-window reference model (output high iff the last
// NONOVERLAP raw samples all agree) checked every cycle, plus directed period counts.
module tb_mtr_drv_pwm;
    import mtr_pkg::*;

    localparam int N = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic signed [10:0] lft_spd = '0;
    logic signed [10:0] rght_spd = '0;
    logic              lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, pwm_sync;

    mtr_drv_pwm #(.NONOVERLAP(N), .CNT_W(11)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .lftPWM1  (lftPWM1),
        .lftPWM2  (lftPWM2),
        .rghtPWM1 (rghtPWM1),
        .rghtPWM2 (rghtPWM2),
        .pwm_sync (pwm_sync)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state: current cycle's counter, loaded duties, raw history per side
    int m_cnt;
    int m_duty_l, m_duty_r;
    bit hq_l[$];
    bit hq_r[$];
    int ones_l, ones_r;

    // per-period tallies: 0 l1, 1 l2, 2 r1, 3 r2, 4 sync
    int acc_dut[5];
    int acc_mod[4];

    task automatic expect_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt    = 0;
        m_duty_l = 1024;
        m_duty_r = 1024;
        hq_l.delete();
        hq_r.delete();
        ones_l = 0;
        ones_r = 0;
    endtask

    task automatic model_advance();
        bit   raw;
        spd_t s;
        raw = (m_cnt < m_duty_l);
        hq_l.push_back(raw);
        if (raw) ones_l++;
        if (hq_l.size() > N) begin
            if (hq_l.pop_front()) ones_l--;
        end
        raw = (m_cnt < m_duty_r);
        hq_r.push_back(raw);
        if (raw) ones_r++;
        if (hq_r.size() > N) begin
            if (hq_r.pop_front()) ones_r--;
        end
        if (m_cnt == PWM_PERIOD - 1) begin
            s = lft_spd;
            m_duty_l = int'(s) + 1024;
            s = rght_spd;
            m_duty_r = int'(s) + 1024;
        end
        m_cnt = (m_cnt + 1) % PWM_PERIOD;
    endtask

    task automatic check();
        logic [4:0] obs, exp;
        logic       ovl;
        exp[4] = (hq_l.size() == N) && (ones_l == N);
        exp[3] = (hq_l.size() == N) && (ones_l == 0);
        exp[2] = (hq_r.size() == N) && (ones_r == N);
        exp[1] = (hq_r.size() == N) && (ones_r == 0);
        exp[0] = (m_cnt == PWM_PERIOD - 1);
        obs = {lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, pwm_sync};
        if (m_cnt == 0) begin
            for (int i = 0; i < 5; i++) acc_dut[i] = 0;
            for (int i = 0; i < 4; i++) acc_mod[i] = 0;
        end
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL cycle_model cnt=%0d observed=%b expected=%b", m_cnt, obs, exp);
        end
        ovl = (lftPWM1 & lftPWM2) | (rghtPWM1 & rghtPWM2);
        n_assert++;
        assert (ovl === 1'b0) else begin
            n_fail++;
            $error("FAIL overlap cnt=%0d observed=%b expected=0", m_cnt, ovl);
        end
        for (int i = 0; i < 5; i++) acc_dut[i] += int'(obs[4-i]);
        for (int i = 0; i < 4; i++) acc_mod[i] += int'(exp[4-i]);
    endtask

    task automatic step();
        @(posedge clk);
        model_advance();
        @(negedge clk);
        check();
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        do begin
            step();
            guard++;
        end while (m_cnt != target && guard < 2 * PWM_PERIOD);
        expect_int("run_to_target", m_cnt, target);
    endtask

    // e_* < 0 skips the spec constant for that output; model counts are always compared
    task automatic chk_period(input string tag, input int e_l1, input int e_l2,
                              input int e_r1, input int e_r2);
        int e[4];
        e = '{e_l1, e_l2, e_r1, e_r2};
        for (int i = 0; i < 4; i++) begin
            if (e[i] >= 0) expect_int($sformatf("%s_cnt%0d", tag, i), acc_dut[i], e[i]);
            expect_int($sformatf("%s_model%0d", tag, i), acc_dut[i], acc_mod[i]);
        end
        expect_int($sformatf("%s_sync", tag), acc_dut[4], 1);
    endtask

    function automatic logic [10:0] rand_spd();
        case ($urandom_range(0, 4))
            0:       return 11'h400;
            1:       return 11'h3FF;
            2:       return 11'(-11'sd1000);
            default: return 11'($urandom_range(0, 2047));
        endcase
    endfunction

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        expect_int("reset_outputs", {lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, pwm_sync}, 0);
        rst_n = 1'b1;
        model_reset();
        check();

        // 1: zero speed, first period after reset then three steady periods
        run_to(2047);
        chk_period("t1_first", 993, 992, 993, 992);
        for (int p = 0; p < 3; p++) begin
            run_to(2047);
            chk_period("t1", 993, 993, 993, 993);
        end

        // 2: full reverse left, full forward right
        lft_spd  = 11'h400;
        rght_spd = 11'h3FF;
        run_to(2047);
        chk_period("t2_a", 0, 2048, 2016, 1);
        run_to(2047);
        chk_period("t2_b", 0, 2048, 2016, 0);

        // 3: mid-period change only takes effect at the next period
        lft_spd  = 11'sd0;
        rght_spd = 11'sd0;
        run_to(2047);
        chk_period("t3_a", 993, 993, 993, 992);
        run_to(500);
        lft_spd = 11'sd512;
        run_to(2047);
        chk_period("t3_b", 993, 993, 993, 993);
        run_to(2047);
        chk_period("t3_c", 1505, 481, 993, 993);

        // 4: duty shorter than the dead-time window
        lft_spd = -11'sd1000;
        run_to(2047);
        chk_period("t4_a", 0, 1993, 993, 993);
        run_to(2047);
        chk_period("t4_b", 0, 1993, 993, 993);

        // 5: asynchronous reset while outputs are high
        lft_spd = 11'sd0;
        run_to(2047);
        run_to(500);
        expect_int("t5_lft_high", lftPWM1, 1);
        expect_int("t5_rght_high", rghtPWM1, 1);
        #2 rst_n = 1'b0;
        #1 expect_int("t5_async_clear", {lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, pwm_sync}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check();
        run_to(2047);
        chk_period("t5_first", 993, 992, 993, 992);
        run_to(2047);
        chk_period("t5_steady", 993, 993, 993, 993);

        // 6: random commands changed at random points in the period
        for (int p = 0; p < 12; p++) begin
            run_to(int'($urandom_range(0, 2046)));
            lft_spd  = rand_spd();
            rght_spd = rand_spd();
            run_to(2047);
            chk_period("t6", -1, -1, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
